mem_bridge: RTL and testbench
=============================

# mem_bridge

Data-memory bus bridge between the CPU control/datapath and the Avalon-MM memory port. It converts the control unit's `ram_*` request strobes and width-coded byte mask into word-aligned Avalon transfers. It holds each transfer across `waitrequest` and drives the `stall_i` seen by the control unit. For loads it also returns lane-aligned, sign- or zero-extended read data.

## Interface
- No parameters; address and data widths are fixed at 32.
- `clk` in 1: single clock; all state on rising edge.
- `reset` in 1: asynchronous, active-high.
- `ram_read_en_i` in 1: load request from control.
- `ram_write_en_i` in 1: store request from control.
- `ram_byte_en_i` in 4: width code. `1111` = word, `1100` = half, `1000` = byte. Any other value is treated as word.
- `ram_addr_i` in 32: byte address.
- `ram_writedata_i` in 32: store data, right-justified.
- `load_signed_i` in 1: 1 = sign-extend, 0 = zero-extend.
- `avm_address_o` out 32: `{addr[31:2],2'b00}`.
- `avm_read_o` out 1: Avalon read strobe.
- `avm_write_o` out 1: Avalon write strobe.
- `avm_byteenable_o` out 4: lane mask.
- `avm_writedata_o` out 32: lane-shifted store data.
- `avm_waitrequest_i` in 1: Avalon wait.
- `avm_readdata_i` in 32: valid on the cycle after read acceptance.
- `stall_o` out 1: to control `stall_i`.
- `readdata_o` out 32: aligned, extended load result.
- `readdata_valid_o` out 1: one-cycle pulse.
- `align_err_o` out 1: one-cycle pulse on a misaligned request.

## Operation
- FSM states:
  - IDLE: drives Avalon combinationally from the inputs.
  - HOLD: drives Avalon from the registered request.
  - RESP: read-data capture cycle.
- Request = `ram_write_en_i | ram_read_en_i`. If both are asserted, the write wins and the read is dropped.
- Lane offset `off = addr[1:0]`.
  - Byte enable: byte `0001<<off`, half `0011<<off`, word `1111`.
  - Write data: `ram_writedata_i << 8*off`.
- IDLE with a request:
  - If `avm_waitrequest_i` = 0, the transfer is accepted this cycle.
    - Read → RESP.
    - Write → stays in IDLE.
  - If `avm_waitrequest_i` = 1, latch address, byte enable, write data, kind and `load_signed_i`, then → HOLD.
- HOLD: outputs come from the latched request; later input changes are ignored. When `avm_waitrequest_i` falls, the transfer is accepted: read → RESP, write → IDLE.
- RESP:
  - Capture `avm_readdata_i >> 8*off_latched`.
  - Extend from bit 7 (byte) or bit 15 (half) per the latched sign flag.
  - Register into `readdata_o` and pulse `readdata_valid_o`.
  - A new request present in RESP is processed as in IDLE (back-to-back accesses allowed).
- `stall_o = request_active & avm_waitrequest_i`, where `request_active` = an IDLE/RESP request, or being in HOLD.
- `readdata_o` holds its last value until the next load completes.

## Timing
- Reset (async, any state, including mid-HOLD):
  - State = IDLE.
  - `avm_read_o`, `avm_write_o`, `stall_o`, `readdata_valid_o` and `align_err_o` = 0.
  - `avm_byteenable_o` = 0, `avm_address_o` = 0, `avm_writedata_o` = 0, `readdata_o` = 0.
  - The aborted transfer is never reissued.
- Zero-wait write: strobe and acceptance in the same cycle as the request; no stall.
- Zero-wait read: accepted in cycle N; `readdata_valid_o` and `readdata_o` are updated at the edge ending cycle N+1, i.e. visible in N+2.
- Wait states: one `stall_o` cycle per `avm_waitrequest_i` cycle. Acceptance occurs on the first cycle with `waitrequest` = 0. Read data follows acceptance by the same +1/+2 rule.
- Avalon outputs are stable throughout HOLD; strobes are deasserted the cycle after acceptance unless a new request is present.

## Configuration
- `MEM_BRIDGE_ALIGN_CHECK_EN` defined:
  - A half at odd `off`, or a word at nonzero `off`, produces no bus access.
  - `align_err_o` pulses for one cycle, with `stall_o` = 0.
  - A misaligned read gives no `readdata_valid_o`.
- Undefined:
  - `align_err_o` is tied to 0.
  - Half uses `off[1]` only (`off[0]` is ignored).
  - Word ignores `off` entirely.

## Test plan
- Reset asserted mid-HOLD with `waitrequest` = 1 → all strobes and `stall_o` go to 0 immediately; after release, no transfer occurs without a new request.
- Zero-wait word write, addr `0x100`, data `0xDEADBEEF` → in the same cycle `avm_write_o` = 1, byte enable `1111`, address `0x100`, `stall_o` = 0.
- Byte store, addr `0x103`, data `0x000000A5` → byte enable `1000`, write data `0xA5000000`.
- Signed byte load, addr `0x102`, readdata `0x00800000`, waitrequest held 3 cycles → `stall_o` high for 3 cycles; then `readdata_o` = `0xFFFFFF80` and `readdata_valid_o` pulses once.
- Unsigned half load at addr `0x202`, readdata `0x8001xxxx`, zero-wait → `readdata_o` = `0x00008001`. Back-to-back with a write issued in the RESP cycle → both accepted, no extra stall.
- With `MEM_BRIDGE_ALIGN_CHECK_EN`, word load at `0x101` → no `avm_read_o`, `align_err_o` = 1 for 1 cycle, no valid pulse.

Source files
------------

// File: rtl/mem_bridge.sv
// Data-memory bridge: CPU ram_* request strobes to word-aligned Avalon-MM transfers, with lane-aligned load extension.
// Optional misalignment trapping is compiled in with MEM_BRIDGE_ALIGN_CHECK_EN.
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | Avalon driven combinationally from the current request
// S_HOLD | Avalon driven from the latched request until waitrequest drops
// S_RESP | read data capture; a new request is handled as in S_IDLE
module mem_bridge (
    input  logic        clk,
    input  logic        reset,
    input  logic        ram_read_en_i,
    input  logic        ram_write_en_i,
    input  logic [3:0]  ram_byte_en_i,
    input  logic [31:0] ram_addr_i,
    input  logic [31:0] ram_writedata_i,
    input  logic        load_signed_i,
    output logic [31:0] avm_address_o,
    output logic        avm_read_o,
    output logic        avm_write_o,
    output logic [3:0]  avm_byteenable_o,
    output logic [31:0] avm_writedata_o,
    input  logic        avm_waitrequest_i,
    input  logic [31:0] avm_readdata_i,
    output logic        stall_o,
    output logic [31:0] readdata_o,
    output logic        readdata_valid_o,
    output logic        align_err_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HOLD = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic [1:0] W_BYTE = 2'd0;
    localparam logic [1:0] W_HALF = 2'd1;
    localparam logic [1:0] W_WORD = 2'd2;

    state_t      state_q, state_d;

    logic [29:0] addr_q;
    logic [3:0]  be_q;
    logic [31:0] wdata_q;
    logic        is_read_q;
    logic        signed_q;
    logic [1:0]  width_q;
    logic [1:0]  lane_q;
    logic [31:0] rdata_q;
    logic        rvalid_q;

    logic        req_any;
    logic        req_is_read;
    logic [1:0]  off;
    logic [1:0]  req_width;
    logic [1:0]  req_lane;
    logic        req_misaligned;
    logic        req_ok;
    logic [3:0]  req_be;
    logic [31:0] req_wdata;
    logic [31:0] rd_shifted;
    logic [31:0] rd_ext;

    assign req_any     = ram_write_en_i | ram_read_en_i;
    assign req_is_read = ram_read_en_i & ~ram_write_en_i;
    assign off         = ram_addr_i[1:0];

    always_comb begin
        req_width = W_WORD;
        req_lane  = 2'b00;
        req_be    = 4'b1111;
        case (ram_byte_en_i)
            4'b1000: begin
                req_width = W_BYTE;
                req_lane  = off;
                req_be    = 4'b0001 << off;
            end
            4'b1100: begin
                req_width = W_HALF;
                req_lane  = {off[1], 1'b0};
                req_be    = 4'b0011 << {off[1], 1'b0};
            end
            default: ;
        endcase
    end

`ifdef MEM_BRIDGE_ALIGN_CHECK_EN
    assign req_misaligned = ((req_width == W_HALF) & off[0]) |
                            ((req_width == W_WORD) & (off != 2'b00));
`else
    assign req_misaligned = 1'b0;
`endif

    assign req_wdata = ram_writedata_i << {req_lane, 3'b000};
    // HOLD ignores the live inputs entirely, so a request only counts outside it.
    assign req_ok    = req_any & ~req_misaligned & (state_q != S_HOLD);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = S_IDLE;
        case (state_q)
            S_IDLE, S_RESP: begin
                if (req_ok) begin
                    if (avm_waitrequest_i) begin
                        state_d = S_HOLD;
                    end else if (req_is_read) begin
                        state_d = S_RESP;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_HOLD: begin
                if (avm_waitrequest_i) begin
                    state_d = S_HOLD;
                end else if (is_read_q) begin
                    state_d = S_RESP;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        avm_address_o    = 32'h0;
        avm_read_o       = 1'b0;
        avm_write_o      = 1'b0;
        avm_byteenable_o = 4'h0;
        avm_writedata_o  = 32'h0;
        stall_o          = 1'b0;
        align_err_o      = 1'b0;
        // Reset is asynchronous, so the combinational IDLE path must be masked too.
        if (!reset) begin
            if (state_q == S_HOLD) begin
                avm_address_o    = {addr_q, 2'b00};
                avm_read_o       = is_read_q;
                avm_write_o      = ~is_read_q;
                avm_byteenable_o = be_q;
                avm_writedata_o  = wdata_q;
                stall_o          = avm_waitrequest_i;
            end else if (req_ok) begin
                avm_address_o    = {ram_addr_i[31:2], 2'b00};
                avm_read_o       = req_is_read;
                avm_write_o      = ~req_is_read;
                avm_byteenable_o = req_be;
                avm_writedata_o  = req_wdata;
                stall_o          = avm_waitrequest_i;
            end
`ifdef MEM_BRIDGE_ALIGN_CHECK_EN
            align_err_o = req_any & req_misaligned & (state_q != S_HOLD);
`endif
        end
    end

    assign rd_shifted = avm_readdata_i >> {lane_q, 3'b000};

    always_comb begin
        rd_ext = rd_shifted;
        case (width_q)
            W_BYTE:  rd_ext = {{24{signed_q & rd_shifted[7]}}, rd_shifted[7:0]};
            W_HALF:  rd_ext = {{16{signed_q & rd_shifted[15]}}, rd_shifted[15:0]};
            default: rd_ext = rd_shifted;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q    <= 30'h0;
            be_q      <= 4'h0;
            wdata_q   <= 32'h0;
            is_read_q <= 1'b0;
            signed_q  <= 1'b0;
            width_q   <= W_WORD;
            lane_q    <= 2'b00;
            rdata_q   <= 32'h0;
            rvalid_q  <= 1'b0;
        end else begin
            // Latched on every accepted or stalled request: HOLD drives from it, RESP decodes with it.
            if (req_ok) begin
                addr_q    <= ram_addr_i[31:2];
                be_q      <= req_be;
                wdata_q   <= req_wdata;
                is_read_q <= req_is_read;
                signed_q  <= load_signed_i;
                width_q   <= req_width;
                lane_q    <= req_lane;
            end
            rvalid_q <= (state_q == S_RESP);
            if (state_q == S_RESP) begin
                rdata_q <= rd_ext;
            end
        end
    end

    assign readdata_o       = rdata_q;
    assign readdata_valid_o = rvalid_q;

endmodule

// File: tb/tb_mem_bridge.sv
// Randomized bench for mem_bridge against a transaction-level model of lane mapping and load extension.
// Define MEM_BRIDGE_ALIGN_CHECK_EN for both bench and RTL to exercise misalignment trapping.
module tb_mem_bridge;

    logic        clk = 1'b0;
    logic        reset;
    logic        ram_read_en_i;
    logic        ram_write_en_i;
    logic [3:0]  ram_byte_en_i;
    logic [31:0] ram_addr_i;
    logic [31:0] ram_writedata_i;
    logic        load_signed_i;
    logic [31:0] avm_address_o;
    logic        avm_read_o;
    logic        avm_write_o;
    logic [3:0]  avm_byteenable_o;
    logic [31:0] avm_writedata_o;
    logic        avm_waitrequest_i;
    logic [31:0] avm_readdata_i;
    logic        stall_o;
    logic [31:0] readdata_o;
    logic        readdata_valid_o;
    logic        align_err_o;

    mem_bridge dut (
        .clk               (clk),
        .reset             (reset),
        .ram_read_en_i     (ram_read_en_i),
        .ram_write_en_i    (ram_write_en_i),
        .ram_byte_en_i     (ram_byte_en_i),
        .ram_addr_i        (ram_addr_i),
        .ram_writedata_i   (ram_writedata_i),
        .load_signed_i     (load_signed_i),
        .avm_address_o     (avm_address_o),
        .avm_read_o        (avm_read_o),
        .avm_write_o       (avm_write_o),
        .avm_byteenable_o  (avm_byteenable_o),
        .avm_writedata_o   (avm_writedata_o),
        .avm_waitrequest_i (avm_waitrequest_i),
        .avm_readdata_i    (avm_readdata_i),
        .stall_o           (stall_o),
        .readdata_o        (readdata_o),
        .readdata_valid_o  (readdata_valid_o),
        .align_err_o       (align_err_o)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Read-response bookkeeping
    bit          rd_pending = 1'b0;
    int          rd_n;
    int          rd_lane;
    bit          rd_sgn;
    bit          rd_force = 1'b0;
    logic [31:0] rd_force_val;
    bit          valid_next = 1'b0;
    logic [31:0] exp_next;
    bit          cur_valid = 1'b0;
    logic [31:0] last_rd = 32'h0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int nbytes(input logic [3:0] code);
        case (code)
            4'b1000: return 1;
            4'b1100: return 2;
            default: return 4;
        endcase
    endfunction

    function automatic int lane_of(input int n, input int off);
        if (n == 1) return off;
        if (n == 2) return off & 2;
        return 0;
    endfunction

    function automatic bit misaligned(input int n, input int off);
`ifdef MEM_BRIDGE_ALIGN_CHECK_EN
        return (n == 2 && (off % 2) != 0) || (n == 4 && off != 0);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [3:0] exp_be(input int n, input int lane);
        logic [3:0] m;
        if (n == 4) return 4'hF;
        m = (n == 2) ? 4'h3 : 4'h1;
        return m << lane;
    endfunction

    function automatic logic [31:0] exp_load(input logic [31:0] rd, input int n, input int lane, input bit sgn);
        logic [31:0] v;
        v = rd >> (8 * lane);
        if (n == 1) begin
            v = v & 32'hFF;
            if (sgn && v >= 32'h80) v = v | 32'hFFFF_FF00;
        end else if (n == 2) begin
            v = v & 32'hFFFF;
            if (sgn && v >= 32'h8000) v = v | 32'hFFFF_0000;
        end
        return v;
    endfunction

    // Called just after each rising edge: advance response expectations and feed read data.
    task automatic begin_cycle();
        cur_valid = valid_next;
        if (cur_valid) last_rd = exp_next;
        valid_next = 1'b0;
        if (rd_pending) begin
            avm_readdata_i = rd_force ? rd_force_val : $urandom;
            exp_next       = exp_load(avm_readdata_i, rd_n, rd_lane, rd_sgn);
            valid_next     = 1'b1;
            rd_pending     = 1'b0;
            rd_force       = 1'b0;
        end else begin
            avm_readdata_i = $urandom;
        end
    endtask

    task automatic check_resp();
        chk("rvalid", {31'h0, readdata_valid_o}, {31'h0, cur_valid});
        chk("rdata", readdata_o, last_rd);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
        begin_cycle();
    endtask

    task automatic idle(input int cycles);
        ram_read_en_i  = 1'b0;
        ram_write_en_i = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            avm_waitrequest_i = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk("idle_rd", {31'h0, avm_read_o}, 32'h0);
            chk("idle_wr", {31'h0, avm_write_o}, 32'h0);
            chk("idle_stall", {31'h0, stall_o}, 32'h0);
            check_resp();
            next_cycle();
        end
    endtask

    // One CPU access; returns at the start of the cycle after acceptance (the RESP cycle for reads).
    task automatic access(input bit is_wr, input bit both, input logic [31:0] addr,
                          input logic [31:0] data, input logic [3:0] code,
                          input bit sgn, input int waits);
        int n, off, lane;
        n    = nbytes(code);
        off  = int'(addr[1:0]);
        lane = lane_of(n, off);
        ram_write_en_i  = is_wr;
        ram_read_en_i   = !is_wr || both;
        ram_addr_i      = addr;
        ram_writedata_i = data;
        ram_byte_en_i   = code;
        load_signed_i   = sgn;
        if (misaligned(n, off)) begin
            avm_waitrequest_i = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk("mis_rd", {31'h0, avm_read_o}, 32'h0);
            chk("mis_wr", {31'h0, avm_write_o}, 32'h0);
            chk("mis_stall", {31'h0, stall_o}, 32'h0);
            chk("mis_err", {31'h0, align_err_o}, 32'h1);
            check_resp();
            next_cycle();
        end else begin
            for (int c = 0; c <= waits; c++) begin
                avm_waitrequest_i = (c < waits);
                if (c > 0) begin
                    ram_addr_i      = $urandom;
                    ram_writedata_i = $urandom;
                    ram_byte_en_i   = 4'($urandom);
                    load_signed_i   = 1'($urandom);
                end
                @(negedge clk);
                chk("stall", {31'h0, stall_o}, {31'h0, (c < waits)});
                chk("rd_strobe", {31'h0, avm_read_o}, {31'h0, !is_wr});
                chk("wr_strobe", {31'h0, avm_write_o}, {31'h0, is_wr});
                chk("address", avm_address_o, {addr[31:2], 2'b00});
                chk("byteen", {28'h0, avm_byteenable_o}, {28'h0, exp_be(n, lane)});
                if (is_wr) chk("wdata", avm_writedata_o, data << (8 * lane));
                chk("align_err", {31'h0, align_err_o}, 32'h0);
                check_resp();
                if (c == waits && !is_wr) begin
                    rd_pending = 1'b1;
                    rd_n       = n;
                    rd_lane    = lane;
                    rd_sgn     = sgn;
                end
                next_cycle();
            end
        end
        ram_read_en_i     = 1'b0;
        ram_write_en_i    = 1'b0;
        avm_waitrequest_i = 1'b0;
    endtask

    initial begin
        reset             = 1'b1;
        ram_write_en_i    = 1'b1;
        ram_read_en_i     = 1'b1;
        ram_byte_en_i     = 4'b1111;
        ram_addr_i        = 32'h0000_0123;
        ram_writedata_i   = 32'h1234_5678;
        load_signed_i     = 1'b0;
        avm_waitrequest_i = 1'b1;
        avm_readdata_i    = 32'h0;
        #3;
        chk("rst_rd", {31'h0, avm_read_o}, 32'h0);
        chk("rst_wr", {31'h0, avm_write_o}, 32'h0);
        chk("rst_stall", {31'h0, stall_o}, 32'h0);
        chk("rst_addr", avm_address_o, 32'h0);
        chk("rst_be", {28'h0, avm_byteenable_o}, 32'h0);
        chk("rst_wdata", avm_writedata_o, 32'h0);
        chk("rst_rdata", readdata_o, 32'h0);
        chk("rst_rvalid", {31'h0, readdata_valid_o}, 32'h0);
        chk("rst_align", {31'h0, align_err_o}, 32'h0);
        ram_write_en_i    = 1'b0;
        ram_read_en_i     = 1'b0;
        avm_waitrequest_i = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        next_cycle();
        idle(2);

        // Reset in the middle of a stalled write
        ram_write_en_i    = 1'b1;
        ram_byte_en_i     = 4'b1111;
        ram_addr_i        = 32'h0000_0040;
        ram_writedata_i   = 32'hCAFE_F00D;
        avm_waitrequest_i = 1'b1;
        @(negedge clk);
        chk("hold0_stall", {31'h0, stall_o}, 32'h1);
        @(posedge clk);
        #1;
        ram_write_en_i = 1'b0;
        #1;
        chk("hold1_wr", {31'h0, avm_write_o}, 32'h1);
        chk("hold1_stall", {31'h0, stall_o}, 32'h1);
        #1;
        reset = 1'b1;
        #1;
        chk("midrst_wr", {31'h0, avm_write_o}, 32'h0);
        chk("midrst_stall", {31'h0, stall_o}, 32'h0);
        chk("midrst_be", {28'h0, avm_byteenable_o}, 32'h0);
        chk("midrst_addr", avm_address_o, 32'h0);
        avm_waitrequest_i = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        next_cycle();
        idle(3);

        // Directed scenarios
        access(1'b1, 1'b0, 32'h0000_0100, 32'hDEAD_BEEF, 4'b1111, 1'b0, 0);
        access(1'b1, 1'b0, 32'h0000_0103, 32'h0000_00A5, 4'b1000, 1'b0, 0);
        idle(1);
        rd_force = 1'b1;
        rd_force_val = 32'h0080_0000;
        access(1'b0, 1'b0, 32'h0000_0102, 32'h0, 4'b1000, 1'b1, 3);
        idle(1);
        chk("sbyte_load", readdata_o, 32'hFFFF_FF80);
        idle(1);
        rd_force = 1'b1;
        rd_force_val = 32'h8001_5A5A;
        access(1'b0, 1'b0, 32'h0000_0202, 32'h0, 4'b1100, 1'b0, 0);
        access(1'b1, 1'b0, 32'h0000_0300, 32'h1111_2222, 4'b1111, 1'b0, 0);
        chk("uhalf_load", readdata_o, 32'h0000_8001);
        idle(1);
`ifdef MEM_BRIDGE_ALIGN_CHECK_EN
        access(1'b0, 1'b0, 32'h0000_0101, 32'h0, 4'b1111, 1'b0, 0);
        idle(2);
`endif

        // Random traffic, including back-to-back accesses and write+read collisions
        for (int k = 0; k < 300; k++) begin
            logic [3:0] code;
            case ($urandom_range(0, 4))
                0: code = 4'b1000;
                1: code = 4'b1100;
                2: code = 4'b1111;
                default: code = 4'($urandom);
            endcase
            access(1'($urandom), ($urandom_range(0, 7) == 0), $urandom, $urandom, code,
                   1'($urandom), $urandom_range(0, 3));
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
        end
        idle(3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
